// File: rtl/ucode_loader_pkg.sv
// Shared definitions for the writable control store and its loader.
//   AW           : control-store address width (matches the micro-PC)
//   DW           : microinstruction width, always three stream bytes
//   SYNC_DEFAULT : byte value that opens a load frame
//   state_e      : loader FSM states, 3-bit encoding
package ucode_loader_pkg;

  localparam int          AW           = 8;
  localparam int          DW           = 24;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_CNT  = 3'd2,
    ST_DH   = 3'd3,
    ST_DM   = 3'd4,
    ST_DL   = 3'd5,
    ST_WR   = 3'd6,
    ST_CHK  = 3'd7
  } state_e;

endpackage

// File: rtl/ucode_loader.sv
// Control-store writer. Takes a framed byte stream over valid/ready,
// assembles 24-bit microinstructions and writes them into the writable
// control store, holding the CPU while a frame is in flight.
//
// Frame: SYNC, ADDR, CNT, CNT x {D[23:16], D[15:8], D[7:0]}, CHK
//        CNT = 0 means 256 words; CHK = XOR of ADDR, CNT and all data bytes.
//
// Ports
//   clk_i        : single clock, all state changes on posedge
//   rst_ni       : synchronous active-low reset
//   in_data_i    : stream byte
//   in_valid_i   : in_data_i is valid
//   in_ready_o   : loader accepts a byte this cycle
//   we_rom_o     : control-store write strobe, one cycle per word
//   waddr_rom_o  : control-store write address
//   wdata_rom_o  : control-store write data
//   cpu_hold_o   : CPU must not run
//   done_o       : one-cycle pulse after the CHK byte is accepted
//   err_o        : sticky checksum-mismatch flag for the last frame
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for SYNC, other bytes dropped
// ADDR  | latch base address, seed checksum
// CNT   | latch word count (0 -> 256)
// DH    | data byte [23:16]
// DM    | data byte [15:8]
// DL    | data byte [7:0], launches the write
// WR    | write strobe cycle, input stalled, address/count advance
// CHK   | compare checksum byte, update err, pulse done
module ucode_loader
  import ucode_loader_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          we_rom_o,
  output logic [AW-1:0] waddr_rom_o,
  output logic [DW-1:0] wdata_rom_o,
  output logic          cpu_hold_o,
  output logic          done_o,
  output logic          err_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [15:0]   asm_q, asm_d;   // upper two bytes of the word being built
  logic [7:0]    chk_q, chk_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          xfer;

  // Ready is gated by reset directly so no byte is taken while in reset.
  assign in_ready_o = rst_ni && (state_q != ST_WR);
  assign xfer       = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      chk_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      chk_q   <= chk_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    chk_d   = chk_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer && (in_data_i == SYNC)) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (xfer) begin
          addr_d  = in_data_i;
          chk_d   = in_data_i;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (xfer) begin
          cnt_d   = (in_data_i == 8'h00) ? 9'd256 : {1'b0, in_data_i};
          chk_d   = chk_q ^ in_data_i;
          state_d = ST_DH;
        end
      end
      ST_DH, ST_DM: begin
        if (xfer) begin
          asm_d   = {asm_q[7:0], in_data_i};
          chk_d   = chk_q ^ in_data_i;
          state_d = (state_q == ST_DH) ? ST_DM : ST_DL;
        end
      end
      ST_DL: begin
        // Write outputs are registered here so the strobe lines up with WR.
        if (xfer) begin
          chk_d   = chk_q ^ in_data_i;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {asm_q, in_data_i};
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        addr_d  = addr_q + AW'(1);
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? ST_CHK : ST_DH;
      end
      ST_CHK: begin
        if (xfer) begin
          err_d   = (in_data_i != chk_q);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign we_rom_o    = we_q;
  assign waddr_rom_o = waddr_q;
  assign wdata_rom_o = wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  // done_q extends the hold through the done cycle, when the FSM is already idle.
  assign cpu_hold_o  = (state_q != ST_IDLE) || done_q;

endmodule

// File: tb/tb_ucode_loader.sv
module tb_ucode_loader;
  import ucode_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          we_rom;
  logic [AW-1:0] waddr_rom;
  logic [DW-1:0] wdata_rom;
  logic          cpu_hold;
  logic          done;
  logic          err;

  ucode_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .we_rom_o    (we_rom),
    .waddr_rom_o (waddr_rom),
    .wdata_rom_o (wdata_rom),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] wlog[$];
  int          done_seen = 0;
  int          hold_viol = 0;
  int          rdy_viol = 0;
  bit          in_frame = 1'b0;
  logic        err_model = 1'b0;

  // Passive observer: records writes and protocol violations away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_rom) wlog.push_back({waddr_rom, wdata_rom});
      if (we_rom && in_ready) rdy_viol++;
      if (in_frame != cpu_hold) hold_viol++;
      if (done) begin
        done_seen++;
        in_frame = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    g = $urandom_range(maxgap, 0);
    t = 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Reference: a frame writes word i to (base+i) mod 256; err follows the CHK compare.
  task automatic run_frame(input logic [7:0] base, input int n, input logic [23:0] w[$],
                           input logic [7:0] chk_mask, input int maxgap, input string tag);
    logic [7:0]  chk;
    logic [7:0]  cb;
    logic [7:0]  a;
    logic [31:0] exp_q[$];
    logic        exp_err;
    wlog.delete();
    done_seen = 0; hold_viol = 0; rdy_viol = 0;
    send_byte(SYNC_DEFAULT, maxgap);
    in_frame = 1'b1;
    cb  = n[7:0];
    chk = base ^ cb;
    send_byte(base, maxgap);
    n_cmp++;
    if (err !== err_model) begin
      n_bad++;
      $display("FAIL %s err_sticky: err=%0b required %0b", tag, err, err_model);
    end
    send_byte(cb, maxgap);
    for (int i = 0; i < n; i++) begin
      a = base + i[7:0];
      exp_q.push_back({a, w[i]});
      chk = chk ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
      send_byte(w[i][23:16], maxgap);
      send_byte(w[i][15:8], maxgap);
      send_byte(w[i][7:0], maxgap);
    end
    exp_err = (chk_mask != 8'h00);
    send_byte(chk ^ chk_mask, maxgap);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || err !== exp_err) begin
      n_bad++;
      $display("FAIL %s done_pulse: done=%0b err=%0b required done=1 err=%0b", tag, done, err, exp_err);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || cpu_hold !== 1'b0 || err !== exp_err) begin
      n_bad++;
      $display("FAIL %s after_done: done=%0b hold=%0b err=%0b required 0 0 %0b", tag, done, cpu_hold, err, exp_err);
    end
    err_model = exp_err;
    n_cmp++;
    if (wlog.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s write_count: got %0d required %0d", tag, wlog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (wlog[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL %s write[%0d]: got %h required %h", tag, i, wlog[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (done_seen != 1 || hold_viol != 0 || rdy_viol != 0) begin
      n_bad++;
      $display("FAIL %s protocol: done_pulses=%0d hold_viol=%0d rdy_viol=%0d required 1 0 0",
               tag, done_seen, hold_viol, rdy_viol);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (in_ready !== 1'b0 || we_rom !== 1'b0 || waddr_rom !== '0 || wdata_rom !== '0 ||
        cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s reset_vals: rdy=%0b we=%0b wa=%h wd=%h hold=%0b done=%0b err=%0b required all 0",
               tag, in_ready, we_rom, waddr_rom, wdata_rom, cpu_hold, done, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    err_model = 1'b0;
    #1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%0b hold=%0b required 1 0", in_ready, cpu_hold);
    end
  endtask

  task automatic test_basic();
    logic [23:0] w[$];
    w.push_back(24'h123456);
    run_frame(8'h10, 1, w, 8'h00, 0, "basic");
  endtask

  task automatic test_wrap();
    logic [23:0] w[$];
    w.push_back(24'h000001);
    w.push_back(24'h000002);
    w.push_back(24'h000003);
    run_frame(8'hFE, 3, w, 8'h00, 1, "wrap");
  endtask

  task automatic test_bad_chk();
    logic [23:0] w[$];
    w.push_back(24'h123456);
    // Mask chosen so the sent checksum byte is 00.
    run_frame(8'h10, 1, w, 8'h61, 0, "bad_chk");
    repeat (4) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_chk err_hold: err=%0b required 1", err);
    end
    run_frame(8'h20, 1, w, 8'h00, 1, "clear_err");
  endtask

  task automatic test_noise();
    logic [23:0] w[$];
    wlog.delete();
    hold_viol = 0;
    send_byte(8'h00, 2);
    send_byte(8'h3C, 2);
    send_byte(8'hFF, 2);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wlog.size() != 0 || hold_viol != 0) begin
      n_bad++;
      $display("FAIL noise: writes=%0d hold_viol=%0d required 0 0", wlog.size(), hold_viol);
    end
    w.push_back(24'hA5A5A5);
    w.push_back(24'h00A500);
    run_frame(8'h40, 2, w, 8'h00, 1, "sync_as_data");
  endtask

  task automatic test_reset_mid();
    logic [23:0] w[$];
    w.push_back(24'hABCDEF);
    run_frame(8'h30, 1, w, 8'h5A, 0, "pre_reset_bad");
    wlog.delete();
    send_byte(SYNC_DEFAULT, 0);
    in_frame = 1'b1;
    send_byte(8'h50, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst_n = 1'b0;
    in_frame = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid ready: in_ready=%0b required 0", in_ready);
    end
    send_byte_during_reset();
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
    err_model = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wlog.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid no_write: writes=%0d required 0", wlog.size());
    end
    w.delete();
    w.push_back(24'h0F1E2D);
    run_frame(8'h50, 1, w, 8'h00, 1, "after_reset");
  endtask

  // Offers the final data byte while reset is held; it must not be taken.
  task automatic send_byte_during_reset();
    in_data  = 8'hBE;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [23:0] w[$];
    int          n;
    for (int f = 0; f < 6; f++) begin
      w.delete();
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) w.push_back(24'($urandom));
      run_frame(8'($urandom), n, w, (f == 3) ? 8'h01 : 8'h00, 3, "random");
    end
  endtask

  task automatic test_full();
    logic [23:0] w[$];
    for (int i = 0; i < 256; i++) w.push_back(24'($urandom));
    run_frame(8'($urandom), 256, w, 8'h00, 0, "full256");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_bad_chk();
    test_noise();
    test_reset_mid();
    test_random();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
